input_matrix: RTL

INPUT_MATRIX -- requirements
Module: input_matrix

---
 rtl/input_matrix.sv | 90 +++++++++
 1 files changed

// File: rtl/input_matrix.sv
// Button debounce filter and sm510 K-matrix return path.
// Optional 2-flop input synchronizer enabled by defining INPUT_MATRIX_SYNC_EN.
module input_matrix #(
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned COL_A          = 1,
  parameter int unsigned COL_B          = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic [7:0] buttons,
  input  logic [7:0] shifter_s,
  output logic [3:0] input_k,
  output logic       input_ba,
  output logic       input_beta,
  output logic [7:0] debounced,
  output logic       changed
);

  localparam int unsigned NB    = 8;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] TERM      = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [2:0]       COL_A_IDX = 3'(COL_A);
  localparam logic [2:0]       COL_B_IDX = 3'(COL_B);

  logic [NB-1:0]    synced;
  logic [NB-1:0]    flip;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

`ifdef INPUT_MATRIX_SYNC_EN
  logic [NB-1:0] meta;
  logic [NB-1:0] stable;

  // Two-flop synchronizer; raw buttons reach the filter two clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= '0;
      stable <= '0;
    end else begin
      meta   <= buttons;
      stable <= meta;
    end
  end

  assign synced = stable;
`else
  assign synced = buttons;
`endif

  // Per-button counter: counts consecutive mismatching ticks, flips on reaching TERM.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clk_en) begin
        if (synced[i] != debounced[i]) begin
          if (CNT_W'(cnt_q[i] + CNT_W'(1)) == TERM) begin
            flip[i]  = 1'b1;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      debounced <= '0;
      changed   <= 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      debounced <= debounced ^ flip;
      changed   <= |flip;
    end
  end

  // Matrix return is combinational so the sm510 sees its strobe answered in the same cycle.
  assign input_k = (shifter_s[COL_A_IDX] ? debounced[3:0] : 4'h0) |
                   (shifter_s[COL_B_IDX] ? debounced[7:4] : 4'h0);

  assign input_ba   = 1'b1;
  assign input_beta = 1'b1;

endmodule
